// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: sequential advance over a valid/ready fetch
// handshake, plus branch/jump/JR/exception/ERET redirects, stall and halt/resume.
module pc_fetch_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h8000_0180),
  parameter int               STEP       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] redir_base,
  input  logic             br_taken,
  input  logic [15:0]      br_off,
  input  logic             j_valid,
  input  logic [25:0]      j_index,
  input  logic             jr_valid,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] epc,
  output logic             misalign_err,
  output logic             halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           state;
  logic [WIDTH-1:0] base4;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic             jr_misaligned;

  assign base4         = redir_base + WIDTH'(4);
  assign br_target     = base4 + {{(WIDTH-18){br_off[15]}}, br_off, 2'b00};
  assign j_target      = {base4[WIDTH-1:28], j_index, 2'b00};
  assign jr_misaligned = (jr_target[1:0] != 2'b00);

  assign fetch_valid = (state == RUN) && !stall;
  assign pc_plus4    = pc + WIDTH'(STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      epc          <= '0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      unique case (state)
        BOOT: begin
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN: begin
          if (exc) begin
            pc  <= EXC_VECTOR;
            epc <= exc_pc;
          end else if (eret) begin
            pc <= epc;
          end else if (jr_valid) begin
            if (jr_misaligned) begin
              pc           <= EXC_VECTOR;
              epc          <= jr_target;
              misalign_err <= 1'b1;
            end else begin
              pc <= jr_target;
            end
          end else if (j_valid) begin
            pc <= j_target;
          end else if (br_taken) begin
            pc <= br_target;
          end else if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (fetch_valid && fetch_ready) begin
            pc <= pc_plus4;
          end
        end
        HALTED: begin
          // Only an exception or resume leaves HALTED; other redirects are dropped.
          if (exc) begin
            pc     <= EXC_VECTOR;
            epc    <= exc_pc;
            state  <= RUN;
            halted <= 1'b0;
          end else if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// traffic, all compared against a next-PC reference model kept in the bench.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_V  = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_valid, fetch_ready;
  logic [31:0] pc, pc_plus4, redir_base, jr_target, exc_pc, epc;
  logic        br_taken, j_valid, jr_valid, exc, eret, halt_req, resume;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic        misalign_err, halted;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: 0 = boot, 1 = run, 2 = halted
  int          m_state;
  logic [31:0] m_pc, m_epc;
  logic        m_mis;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus4(pc_plus4),
    .redir_base(redir_base), .br_taken(br_taken), .br_off(br_off),
    .j_valid(j_valid), .j_index(j_index), .jr_valid(jr_valid),
    .jr_target(jr_target), .exc(exc), .exc_pc(exc_pc), .eret(eret),
    .halt_req(halt_req), .resume(resume), .epc(epc),
    .misalign_err(misalign_err), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("epc", epc, m_epc);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, (m_state == 1) && !stall});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    check("halted", {31'd0, halted}, {31'd0, m_state == 2});
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = RST_PC; m_epc = 32'd0; m_mis = 1'b0;
  endtask

  // Next-PC rules written straight from the priority list.
  task automatic model_step();
    logic [31:0] b4;
    b4    = redir_base + 32'd4;
    m_mis = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (exc) begin
      m_pc = EXC_V; m_epc = exc_pc; m_state = 1;
    end else if (m_state == 2) begin
      if (resume) m_state = 1;
    end else if (eret) begin
      m_pc = m_epc;
    end else if (jr_valid) begin
      if (jr_target % 4 != 0) begin
        m_pc = EXC_V; m_epc = jr_target; m_mis = 1'b1;
      end else m_pc = jr_target;
    end else if (j_valid) begin
      m_pc = (b4 & 32'hF000_0000) | ({6'd0, j_index} * 32'd4);
    end else if (br_taken) begin
      m_pc = b4 + 32'($signed(br_off)) * 32'd4;
    end else if (halt_req) begin
      m_state = 2;
    end else if (!stall && fetch_ready) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; j_valid = 0; jr_valid = 0; exc = 0; eret = 0;
    halt_req = 0; resume = 0; redir_base = 0; br_off = 0; j_index = 0;
    jr_target = 0; exc_pc = 0;
  endtask

  initial begin
    clr();
    fetch_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    check_all();

    // boot cycle then sequential fetch 0,4,8
    repeat (3) cycle();
    check("seq_pc8", pc, 32'h8);

    fetch_ready = 1'b0;
    repeat (3) cycle();
    check("hold_pc8", pc, 32'h8);
    fetch_ready = 1'b1;
    cycle();
    check("resume_pc12", pc, 32'hC);
    stall = 1'b1;
    repeat (2) cycle();
    clr();

    br_taken = 1; redir_base = 32'h100; br_off = 16'hFFFE;
    cycle();
    check("branch_neg", pc, 32'hFC);
    clr();
    j_valid = 1; redir_base = 32'h1000_0000; j_index = 26'h40;
    cycle();
    check("jump", pc, 32'h1000_0100);
    clr();
    j_valid = 1; br_taken = 1; redir_base = 32'h1000_0000; j_index = 26'h80; br_off = 16'h10;
    cycle();
    check("jump_over_br", pc, 32'h1000_0200);
    clr();

    jr_valid = 1; jr_target = 32'h2002;
    cycle();
    check("jr_mis_pc", pc, EXC_V);
    check("jr_mis_epc", epc, 32'h2002);
    check("jr_mis_flag", {31'd0, misalign_err}, 32'd1);
    clr();
    cycle();
    check("jr_mis_pulse", {31'd0, misalign_err}, 32'd0);
    jr_valid = 1; jr_target = 32'h2000;
    cycle();
    check("jr_ok", pc, 32'h2000);
    clr();

    exc = 1; exc_pc = 32'h44; eret = 1; br_taken = 1; redir_base = 32'h300;
    cycle();
    check("exc_pc", pc, EXC_V);
    check("exc_epc", epc, 32'h44);
    clr();
    cycle();
    eret = 1;
    cycle();
    check("eret", pc, 32'h44);
    clr();

    halt_req = 1;
    cycle();
    check("halted", {31'd0, halted}, 32'd1);
    clr();
    br_taken = 1; redir_base = 32'h500;
    repeat (2) cycle();
    clr();
    resume = 1;
    cycle();
    clr();
    halt_req = 1;
    cycle();
    clr();
    exc = 1; exc_pc = 32'h1234;
    cycle();
    check("halt_exc", pc, EXC_V);
    clr();

    // random traffic, events kept sparse so sequential fetch stays visible
    for (int i = 0; i < 600; i++) begin
      stall       = ($urandom % 4) == 0;
      fetch_ready = ($urandom % 3) != 0;
      exc         = ($urandom % 40) == 0;
      eret        = ($urandom % 30) == 0;
      jr_valid    = ($urandom % 25) == 0;
      j_valid     = ($urandom % 20) == 0;
      br_taken    = ($urandom % 8) == 0;
      halt_req    = ($urandom % 25) == 0;
      resume      = ($urandom % 4) == 0;
      redir_base  = $urandom;
      br_off      = 16'($urandom);
      j_index     = 26'($urandom);
      jr_target   = $urandom;
      if ($urandom % 2 == 0) jr_target[1:0] = 2'b00;
      exc_pc      = $urandom;
      cycle();
    end
    clr();
    fetch_ready = 1'b1;

    // asynchronous reset in the middle of a branch
    br_taken = 1; redir_base = 32'h700; br_off = 16'h8;
    @(posedge clk); #3;
    model_step();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_rst_pc", pc, RST_PC);
    clr();
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and fetch sequencer for the MIPS core. It replaces the fixed PC register and +4 adder with a PC that supports branch, jump, jump-register, exception and ERET redirects, stall, and halt/resume. It drives instruction-memory fetch requests over a valid/ready handshake.

Parameters:
WIDTH, 32, PC/address width; must be >= 32.
RESET_PC, 32'h00000000, PC value loaded on reset; must be 4-byte aligned.
EXC_VECTOR, 32'h80000180, PC value loaded on an exception or misaligned JR.
STEP, 4, sequential increment in bytes.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  pipeline stall; holds PC and suppresses fetch
fetch_valid  out  1  fetch request valid
fetch_ready  in  1  instruction memory accepts request
pc  out  WIDTH  current fetch address
pc_plus4  out  WIDTH  pc + STEP, combinational
redir_base  in  WIDTH  PC of the redirecting instruction
br_taken  in  1  taken conditional branch
br_off  in  16  signed word offset
j_valid  in  1  J/JAL
j_index  in  26  jump index
jr_valid  in  1  JR/JALR
jr_target  in  WIDTH  register target
exc  in  1  exception request
exc_pc  in  WIDTH  faulting PC to save
eret  in  1  return from exception
halt_req  in  1  enter halt
resume  in  1  leave halt
epc  out  WIDTH  saved exception PC
misalign_err  out  1  one-cycle pulse: JR target misaligned
halted  out  1  high in HALTED state

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: pc=RESET_PC, state=BOOT, fetch_valid=0, epc=0, misalign_err=0, halted=0.
- FSM states: BOOT, RUN, HALTED.
  - BOOT -> RUN unconditionally on the first clock edge after reset deasserts. No fetch is issued in BOOT.
  - RUN -> HALTED on halt_req when no redirect is active.
  - HALTED -> RUN on resume or exc.
- fetch_valid = (state==RUN) && !stall. This is registered state, decoded combinationally.
- Target arithmetic, all modulo 2^WIDTH:
  - base4 = redir_base + 4.
  - Branch target = base4 + (sext(br_off) << 2).
  - Jump target = {base4[WIDTH-1:28], j_index, 2'b00}.
  - JR target = jr_target.
- Next-PC priority, evaluated each edge, highest first:
  1. exc: pc <= EXC_VECTOR; epc <= exc_pc. Applies in any state except BOOT. A pending halt_req is ignored.
  2. eret: pc <= epc.
  3. jr_valid:
     - If jr_target[1:0]!=0: pc <= EXC_VECTOR, epc <= jr_target, misalign_err <= 1 for one cycle.
     - Otherwise: pc <= jr_target.
  4. j_valid: pc <= jump target.
  5. br_taken: pc <= branch target.
  6. halt_req (RUN only): pc holds; enter HALTED.
  7. Sequential: pc <= pc + STEP only when fetch_valid && fetch_ready.
  8. Otherwise pc holds.
- Redirects 2–5 are honoured in RUN regardless of stall or fetch_ready; they override any pending request.
- In HALTED, redirects 2–5 are ignored.
- Handshake rule: while fetch_valid && !fetch_ready, pc is stable and not re-ordered.
- Redirects are single-cycle latency: the target appears on pc the cycle after the input is asserted.
- Wrap-around: pc at 2^WIDTH-4 advances to 0 with no flag.
- Reset asserted mid-operation forces the reset values immediately, independent of clk. In-flight redirect inputs are discarded.
- epc changes only on exc or misaligned JR.

Test Plan:
- Reset, then fetch_ready=1 for 4 cycles -> BOOT cycle with fetch_valid=0; then pc = 0, 4, 8, 12.
- fetch_ready=0 for 3 cycles at pc=8 -> pc holds 8 and fetch_valid stays 1; on ready=1, pc becomes 12. stall=1 -> fetch_valid=0 and pc holds.
- Branch with redir_base=0x100, br_off=-2 -> next pc=0xFC. Jump with redir_base=0x10000000, j_index=0x40 -> pc=0x10000100. Assert both together -> jump wins.
- jr_target=0x2002 -> pc=0x80000180, epc=0x2002, misalign_err high exactly one cycle. jr_target=0x2000 -> pc=0x2000.
- exc with exc_pc=0x44 at the same time as eret and br_taken -> pc=0x80000180, epc=0x44. A later eret -> pc=0x44.
- halt_req -> halted=1, fetch_valid=0, pc frozen, br_taken ignored. resume -> RUN at the same pc. exc while halted -> RUN at EXC_VECTOR.
- Assert reset asynchronously mid-branch -> pc=RESET_PC immediately; BOOT state follows.
